risc_controller: RTL and testbench

//  - Sequencer for the VeriRisc CPU and the issuing side of the ALU interface.
//  - Decodes the 3-bit opcode from the instruction register and consumes the ALU zero flag a_is_zero.
//  - Runs an 8-phase instruction cycle and drives all datapath strobes: mux select, memory rd/wr, IR/AC/PC loads, PC increment, bus drive.

---
 rtl/risc_pkg.sv | 30 +++
 rtl/risc_controller_if.sv | 25 ++
 rtl/risc_phase_counter.sv | 27 ++
 rtl/risc_controller.sv | 112 +++++++++++
 tb/tb_risc_controller.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/risc_pkg.sv
// Shared VeriRisc constants: opcodes, instruction-cycle phases and the ALU-op decode.
// Also imported by the ALU so that both sides use the same opcode encoding.
package risc_pkg;

  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  // Opcodes that read a memory operand and write the accumulator.
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/risc_controller_if.sv
// Controller <-> datapath strobe bundle; master = controller, slave = datapath.
interface risc_controller_if;
  logic [2:0] opcode;
  logic       zero;
  logic       sel;
  logic       rd;
  logic       ld_ir;
  logic       inc_pc;
  logic       ld_pc;
  logic       ld_ac;
  logic       wr;
  logic       data_e;
  logic       halt;
  logic [2:0] phase;

  modport master (
    input  opcode, zero,
    output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase
  );

  modport slave (
    output opcode, zero,
    input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase
  );
endinterface

// File: rtl/risc_phase_counter.sv
// 3-bit wrapping instruction-phase counter with synchronous active-low reset.
// Latency: phase advances one step per clk; no handshake, hold freezes the current phase.
module risc_phase_counter
  import risc_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   hold,
  output phase_e phase
);

  phase_e phase_q;
  phase_e phase_d;

  always_ff @(posedge clk) begin
    if (!rst_n) phase_q <= INST_ADDR;
    else        phase_q <= phase_d;
  end

  always_comb begin
    phase_d = phase_q;
    if (!hold) phase_d = phase_e'(phase_q + 3'd1);
  end

  assign phase = phase_q;

endmodule

// File: rtl/risc_controller.sv
// VeriRisc sequencer: 8-phase instruction cycle, combinational strobe decode, sticky halt.
// Latency: strobes follow (phase, opcode, zero) with no added delay; no backpressure, halt freezes at OP_ADDR.
// Optional CTRL_ICOUNT_EN adds the retired-instruction counter instr_cnt.
module risc_controller
  import risc_pkg::*;
`ifdef CTRL_ICOUNT_EN
#(
  parameter int CNT_WIDTH = 16
)
`endif
(
  input  logic                 clk,
  input  logic                 rst_n,
  risc_controller_if.master    bus
`ifdef CTRL_ICOUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] instr_cnt
`endif
);

  phase_e phase;
  logic   halt_q;
  logic   halt_set;
  logic   aluop;
  logic   sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e;

  // Hold on halt_set too, so the phase never leaves OP_ADDR once HLT is seen.
  risc_phase_counter u_phase (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (halt_q | halt_set),
    .phase (phase)
  );

  assign aluop    = is_aluop(bus.opcode);
  assign halt_set = (phase == OP_ADDR) && (bus.opcode == HLT) && !halt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)        halt_q <= 1'b0;
    else if (halt_set) halt_q <= 1'b1;
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    case (phase)
      INST_ADDR:  sel = 1'b1;
      INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      OP_ADDR:    inc_pc = 1'b1;
      OP_FETCH:   rd = aluop;
      ALU_OP: begin
        rd     = aluop;
        inc_pc = (bus.opcode == SKZ) && bus.zero;
        ld_pc  = (bus.opcode == JMP);
        data_e = (bus.opcode == STO);
      end
      STORE: begin
        rd     = aluop;
        ld_ac  = aluop;
        inc_pc = (bus.opcode == JMP);
        ld_pc  = (bus.opcode == JMP);
        wr     = (bus.opcode == STO);
        data_e = (bus.opcode == STO);
      end
      default: ;
    endcase
    // A halted CPU must not touch PC, memory or the bus.
    if (halt_q) begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
      data_e = 1'b0;
    end
  end

  assign bus.sel    = sel;
  assign bus.rd     = rd;
  assign bus.ld_ir  = ld_ir;
  assign bus.inc_pc = inc_pc;
  assign bus.ld_pc  = ld_pc;
  assign bus.ld_ac  = ld_ac;
  assign bus.wr     = wr;
  assign bus.data_e = data_e;
  assign bus.halt   = halt_q;
  assign bus.phase  = phase;

`ifdef CTRL_ICOUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)              instr_cnt <= '0;
    else if (phase == STORE) instr_cnt <= instr_cnt + CNT_WIDTH'(1);
  end
`endif

endmodule

// File: tb/tb_risc_controller.sv
// Directed bench for risc_controller: per-opcode phase/strobe tables, halt freeze, resets.
module tb_risc_controller;
  import risc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  risc_controller_if bus ();

`ifdef CTRL_ICOUNT_EN
  logic [15:0] instr_cnt;
  logic [1:0]  instr_cnt2;
  risc_controller_if bus2 ();
  assign bus2.opcode = bus.opcode;
  assign bus2.zero   = bus.zero;

  risc_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .instr_cnt (instr_cnt)
  );

  risc_controller #(.CNT_WIDTH(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus2),
    .instr_cnt (instr_cnt2)
  );
`else
  risc_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
`endif

  // {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e}
  logic [7:0] strb;
  assign strb = {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc,
                 bus.ld_pc, bus.ld_ac, bus.wr, bus.data_e};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check({tag, "_phase"}, 32'(bus.phase), 32'd0);
    check({tag, "_halt"},  32'(bus.halt),  32'd0);
    check({tag, "_strb"},  32'(strb),      32'h80);
  endtask

  // Runs one full instruction starting at phase 0; e5..e7 are the opcode-specific strobes.
  task automatic run_instr(input string tag, input logic [2:0] op, input logic z,
                           input logic [7:0] e5, input logic [7:0] e6, input logic [7:0] e7);
    logic [7:0] exp [8];
    exp[0] = 8'h80; exp[1] = 8'hC0; exp[2] = 8'hE0; exp[3] = 8'hE0;
    exp[4] = 8'h10; exp[5] = e5;    exp[6] = e6;    exp[7] = e7;
    for (int p = 0; p < 8; p++) begin
      bus.opcode = op;
      bus.zero   = z;
      #1;
      check($sformatf("%s_phase%0d", tag, p), 32'(bus.phase), 32'(p));
      check($sformatf("%s_strb%0d", tag, p),  32'(strb),      32'(exp[p]));
      step();
    end
  endtask

  initial begin
    bus.opcode = ADD;
    bus.zero   = 1'b0;
    do_reset("reset");

    run_instr("add",  ADD, 1'b0, 8'h40, 8'h40, 8'h44);
    run_instr("sto",  STO, 1'b0, 8'h00, 8'h01, 8'h03);
    run_instr("skz1", SKZ, 1'b1, 8'h00, 8'h10, 8'h00);
    run_instr("skz0", SKZ, 1'b0, 8'h00, 8'h00, 8'h00);
    run_instr("jmp",  JMP, 1'b0, 8'h00, 8'h08, 8'h18);
    run_instr("lda",  LDA, 1'b1, 8'h40, 8'h40, 8'h44);

    // Abort an STO in its STORE phase.
    bus.opcode = STO;
    bus.zero   = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("midstore_phase", 32'(bus.phase), 32'd7);
    check("midstore_strb",  32'(strb),      32'h03);
    do_reset("midstore_rst");

    // HLT: one PC increment in phase 4, then frozen with all strobes low.
    bus.opcode = HLT;
    for (int p = 0; p < 5; p++) begin
      #1;
      check($sformatf("hlt_phase%0d", p), 32'(bus.phase), 32'(p));
      check($sformatf("hlt_halt%0d", p),  32'(bus.halt),  32'd0);
      step();
    end
    for (int i = 0; i < 20; i++) begin
      check($sformatf("halted_phase%0d", i), 32'(bus.phase), 32'd4);
      check($sformatf("halted_halt%0d", i),  32'(bus.halt),  32'd1);
      check($sformatf("halted_strb%0d", i),  32'(strb),      32'h00);
      step();
    end
    do_reset("halt_rst");

`ifdef CTRL_ICOUNT_EN
    check("icnt_start", 32'(instr_cnt), 32'd0);
    for (int i = 0; i < 10; i++) run_instr("cnt_add", ADD, 1'b0, 8'h40, 8'h40, 8'h44);
    check("icnt_10",   32'(instr_cnt),  32'd10);
    check("icnt2_10",  32'(instr_cnt2), 32'd2);
    run_instr("cnt_add", ADD, 1'b0, 8'h40, 8'h40, 8'h44);
    check("icnt_11",   32'(instr_cnt),  32'd11);
    check("icnt2_11",  32'(instr_cnt2), 32'd3);
    run_instr("cnt_add", ADD, 1'b0, 8'h40, 8'h40, 8'h44);
    check("icnt_12",   32'(instr_cnt),  32'd12);
    check("icnt2_wrap", 32'(instr_cnt2), 32'd0);
    for (int i = 0; i < 5; i++) step();
    check("icnt_mid_phase", 32'(bus.phase), 32'd5);
    check("icnt_mid_cnt",   32'(instr_cnt), 32'd12);
    do_reset("icnt_rst");
    check("icnt_after_rst",  32'(instr_cnt),  32'd0);
    check("icnt2_after_rst", 32'(instr_cnt2), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
